// File: rtl/analyzer_readback_seq_if.sv
// Memory read-request channel between the readback sequencer (master) and the trace memory port (slave).
interface analyzer_readback_seq_if #(
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned STRIDE = 4
);
  localparam int unsigned LEN_W = $clog2(STRIDE + 1);

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_ack;
  logic              rd_cpl;

  modport master (output rd_req, rd_addr, rd_len, input rd_ack, rd_cpl);
  modport slave  (input rd_req, rd_addr, rd_len, output rd_ack, rd_cpl);
endinterface

// File: rtl/analyzer_readback_seq.sv
// Readback sequencer: walks the circular trace buffer [begin_addr, end_addr) in credit-limited bursts.
// Optional feature: define READBACK_STATS_EN to add the stall_cycles counter output.
module analyzer_readback_seq #(
  parameter int unsigned ADDR_W          = 26,
  parameter int unsigned DEPTH           = 2**26,
  parameter int unsigned STRIDE          = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    capture_idle,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_W-1:0]       begin_addr,
  input  logic [ADDR_W-1:0]       end_addr,
  analyzer_readback_seq_if.master rd,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted
`ifdef READBACK_STATS_EN
  , output logic [31:0]           stall_cycles
`endif
);

  localparam int unsigned LEN_W = $clog2(STRIDE + 1);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]  STRIDE_X = (ADDR_W+1)'(STRIDE);
  localparam logic [CNT_W-1:0] MAX_X    = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [CNT_W-1:0]  outstanding;
  logic              abort_flag;

  logic [ADDR_W:0]   span;
  logic [ADDR_W:0]   burst;
  logic [ADDR_W:0]   addr_sum;
  logic              in_read;
  logic              req;
  logic              accept;
  logic              launch;
  logic              cpl_eff;

  always_comb begin
    // Circular distance: a negative difference wraps by adding DEPTH once.
    span = {1'b0, end_addr} - {1'b0, begin_addr};
    if (end_addr < begin_addr) span = span + DEPTH_X;

    burst    = (remaining < STRIDE_X) ? remaining : STRIDE_X;
    addr_sum = {1'b0, addr} + burst;
    if (addr_sum >= DEPTH_X) addr_sum = addr_sum - DEPTH_X;

    in_read = (state == S_READ);
    req     = in_read && (outstanding < MAX_X) && !abort;
    accept  = req && rd.rd_ack;
    launch  = (state == S_IDLE) && start && capture_idle;
    cpl_eff = rd.rd_cpl && (outstanding != '0);

    rd.rd_req  = req;
    rd.rd_addr = in_read ? addr : '0;
    rd.rd_len  = in_read ? LEN_W'(burst) : '0;

    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    aborted = done && abort_flag;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (launch) state_nxt = (span == '0) ? S_DONE : S_READ;
      S_READ: begin
        if (abort)                             state_nxt = S_DRAIN;
        else if (accept && remaining == burst) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (outstanding == '0) state_nxt = S_DONE;
      S_DONE:  if (!start) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      addr        <= '0;
      remaining   <= '0;
      outstanding <= '0;
      abort_flag  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        addr       <= begin_addr;
        remaining  <= span;
        abort_flag <= 1'b0;
      end
      if (accept) begin
        addr      <= addr_sum[ADDR_W-1:0];
        remaining <= remaining - burst;
      end
      if (in_read && abort) abort_flag <= 1'b1;
      if (state != S_IDLE) begin
        unique case ({accept, cpl_eff})
          2'b10:   outstanding <= outstanding + CNT_W'(1);
          2'b01:   outstanding <= outstanding - CNT_W'(1);
          default: outstanding <= outstanding;
        endcase
      end
    end
  end

`ifdef READBACK_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (launch && span != '0) begin
      stall_cycles <= '0;
    end else if (in_read && remaining != '0 && !accept && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_analyzer_readback_seq.sv
// Bench for analyzer_readback_seq: burst-list reference model with per-cycle compare plus directed literal checks.
module tb_analyzer_readback_seq;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned STRIDE = 4;
  localparam int          MAXO_A = 2;

  typedef struct {int addr; int len;} req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, capture_idle, start, abort;
  logic [ADDR_W-1:0] begin_addr, end_addr;
  logic              busy, done, aborted;
  logic              start_b, abort_b, busy_b, done_b, aborted_b;
  logic              ack_a, man_cpl_a, auto_a;
  logic [1:0]        pipe_a = '0;
  logic [1:0]        pipe_b = '0;
`ifdef READBACK_STATS_EN
  logic [31:0]       stall_a, stall_b;
`endif

  int checks = 0;
  int errors = 0;

  analyzer_readback_seq_if #(.ADDR_W(ADDR_W), .STRIDE(STRIDE)) ifa ();
  analyzer_readback_seq_if #(.ADDR_W(ADDR_W), .STRIDE(STRIDE)) ifb ();

  analyzer_readback_seq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .STRIDE(STRIDE), .MAX_OUTSTANDING(MAXO_A)) dut_a (
    .clk(clk), .reset(reset), .capture_idle(capture_idle), .start(start), .abort(abort),
    .begin_addr(begin_addr), .end_addr(end_addr), .rd(ifa.master),
    .busy(busy), .done(done), .aborted(aborted)
`ifdef READBACK_STATS_EN
    , .stall_cycles(stall_a)
`endif
  );

  analyzer_readback_seq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .STRIDE(STRIDE), .MAX_OUTSTANDING(8)) dut_b (
    .clk(clk), .reset(reset), .capture_idle(capture_idle), .start(start_b), .abort(abort_b),
    .begin_addr(begin_addr), .end_addr(end_addr), .rd(ifb.master),
    .busy(busy_b), .done(done_b), .aborted(aborted_b)
`ifdef READBACK_STATS_EN
    , .stall_cycles(stall_b)
`endif
  );

  assign ifa.rd_ack = ack_a;
  assign ifa.rd_cpl = auto_a ? pipe_a[1] : man_cpl_a;
  assign ifb.rd_ack = 1'b1;
  assign ifb.rd_cpl = pipe_b[1];

  // Memory responder: completion arrives two edges after the accepting edge.
  always @(posedge clk) begin
    if (reset) begin
      pipe_a <= '0;
      pipe_b <= '0;
    end else begin
      pipe_a <= {pipe_a[0], ifa.rd_req & ifa.rd_ack};
      pipe_b <= {pipe_b[0], ifb.rd_req & ifb.rd_ack};
    end
  end

  req_t log_a[$];
  req_t log_b[$];
  int   cpl_cnt_b = 0;

  always @(posedge clk) begin
    if (!reset) begin
      if (ifa.rd_req && ifa.rd_ack) log_a.push_back('{int'(ifa.rd_addr), int'(ifa.rd_len)});
      if (ifb.rd_req && ifb.rd_ack) log_b.push_back('{int'(ifb.rd_addr), int'(ifb.rd_len)});
      if (ifb.rd_cpl) cpl_cnt_b++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the run is a precomputed list of bursts plus a credit counter.
  bit          m_busy = 0, m_done = 0, m_issuing = 0, m_abflag = 0;
  int          m_out = 0;
  req_t        m_q[$];
  int unsigned m_stall = 0;

  always @(posedge clk) begin : model
    bit req, acc, cpl;
    int total;
    req = m_issuing && (m_out < MAXO_A) && !abort;
    acc = req && ack_a;
    cpl = ifa.rd_cpl && (m_out > 0);
    if (reset) begin
      m_busy = 0; m_done = 0; m_issuing = 0; m_abflag = 0; m_out = 0; m_stall = 0;
      m_q.delete();
    end else if (!m_busy) begin
      if (start && capture_idle) begin
        total = (int'(end_addr) - int'(begin_addr) + int'(DEPTH)) % int'(DEPTH);
        m_q.delete();
        for (int off = 0; off < total; off += STRIDE)
          m_q.push_back('{(int'(begin_addr) + off) % int'(DEPTH),
                          (total - off < int'(STRIDE)) ? total - off : int'(STRIDE)});
        m_busy = 1; m_abflag = 0; m_out = 0;
        m_issuing = (m_q.size() != 0);
        m_done = !m_issuing;
        if (m_issuing) m_stall = 0;
      end
    end else if (m_done) begin
      if (!start) begin m_busy = 0; m_done = 0; end
    end else if (m_issuing) begin
      if (!acc && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (abort) begin
        m_issuing = 0; m_abflag = 1;
      end else if (acc) begin
        void'(m_q.pop_front());
        m_issuing = (m_q.size() != 0);
      end
      m_out = m_out + int'(acc) - int'(cpl);
    end else begin
      if (m_out == 0) m_done = 1;
      else m_out = m_out - int'(cpl);
    end
  end

  always @(posedge clk) begin : compare
    #1;
    chk("rd_req",  ifa.rd_req,  m_issuing && (m_out < MAXO_A) && !abort);
    chk("rd_addr", ifa.rd_addr, m_issuing ? m_q[0].addr : 0);
    chk("rd_len",  ifa.rd_len,  m_issuing ? m_q[0].len : 0);
    chk("busy",    busy,        m_busy);
    chk("done",    done,        m_done);
    chk("aborted", aborted,     m_done && m_abflag);
`ifdef READBACK_STATS_EN
    chk("stall_cycles", stall_a, m_stall);
`endif
  end

  task automatic wait_done_a(input int maxc);
    int n = 0;
    while (!done && n < maxc) begin @(negedge clk); n++; end
    chk("wait_done_a", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int base, n;
    bit early;
    reset = 1; start = 0; abort = 0; capture_idle = 1; begin_addr = '0; end_addr = '0;
    ack_a = 0; man_cpl_a = 0; auto_a = 0; start_b = 0; abort_b = 0;
    repeat (2) @(negedge clk);
    chk("reset_rd_req", ifa.rd_req, 0);
    chk("reset_rd_addr", ifa.rd_addr, 0);
    chk("reset_rd_len", ifa.rd_len, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_aborted", aborted, 0);
    reset = 0;

    // start ignored while capture is still running
    capture_idle = 0; start = 1;
    repeat (3) @(negedge clk);
    chk("gate_busy", busy, 0);
    start = 0; capture_idle = 1;
    @(negedge clk);

    // wrap-around run; begin/end changes after launch are ignored
    begin_addr = 6'd60; end_addr = 6'd6; ack_a = 1; auto_a = 1; start = 1;
    base = log_a.size();
    @(negedge clk);
    begin_addr = 6'd5; end_addr = 6'd50;
    wait_done_a(40);
    chk("wrap_count", log_a.size() - base, 3);
    if (log_a.size() >= base + 3) begin
      chk("wrap_a0", log_a[base].addr, 60);   chk("wrap_l0", log_a[base].len, 4);
      chk("wrap_a1", log_a[base+1].addr, 0);  chk("wrap_l1", log_a[base+1].len, 4);
      chk("wrap_a2", log_a[base+1+1].addr, 4); chk("wrap_l2", log_a[base+1+1].len, 2);
    end
    chk("wrap_aborted", aborted, 0);
    start = 0;
    @(negedge clk);
    chk("wrap_idle", busy, 0);

    // rd_ack held low: request stays stable and stalls accumulate
    begin_addr = 6'd0; end_addr = 6'd8; ack_a = 0; start = 1;
    repeat (6) @(negedge clk);
    chk("stall_req_held", ifa.rd_req, 1);
    chk("stall_addr_held", ifa.rd_addr, 0);
`ifdef READBACK_STATS_EN
    chk("stall_count5", stall_a, 5);
`endif
    ack_a = 1;
    wait_done_a(40);
    start = 0;
    @(negedge clk);

    // empty range
    begin_addr = 6'd20; end_addr = 6'd20; start = 1;
    base = log_a.size();
    @(negedge clk);
    chk("empty_done", done, 1);
    chk("empty_aborted", aborted, 0);
    chk("empty_no_req", log_a.size() - base, 0);
    start = 0;
    @(negedge clk);

    // abort with two outstanding
    auto_a = 0; man_cpl_a = 0; begin_addr = 6'd0; end_addr = 6'd40; start = 1;
    base = log_a.size();
    n = 0;
    while (log_a.size() < base + 2 && n < 10) begin @(negedge clk); n++; end
    chk("abort_two_accepts", log_a.size() - base, 2);
    abort = 1;
    #1;
    chk("abort_req_low", ifa.rd_req, 0);
    @(negedge clk);
    abort = 0; man_cpl_a = 1;
    repeat (2) @(negedge clk);
    man_cpl_a = 0;
    wait_done_a(10);
    chk("abort_aborted", aborted, 1);
    chk("abort_total", log_a.size() - base, 2);
    start = 0;
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    chk("abort_idle_nop", busy, 0);
    abort = 0;

    // credit limit, one completion reopens, then reset mid-run
    begin_addr = 6'd0; end_addr = 6'd32; start = 1;
    base = log_a.size();
    repeat (6) @(negedge clk);
    chk("credit_accepts", log_a.size() - base, 2);
    chk("credit_req_low", ifa.rd_req, 0);
    man_cpl_a = 1;
    @(negedge clk);
    man_cpl_a = 0;
    chk("credit_reopen", ifa.rd_req, 1);
    reset = 1; start = 0;
    @(negedge clk);
    chk("midreset_rd_req", ifa.rd_req, 0);
    chk("midreset_rd_addr", ifa.rd_addr, 0);
    chk("midreset_rd_len", ifa.rd_len, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_aborted", aborted, 0);
`ifdef READBACK_STATS_EN
    chk("midreset_stall", stall_a, 0);
`endif
    reset = 0; man_cpl_a = 1;
    repeat (2) @(negedge clk);
    man_cpl_a = 0; auto_a = 1;
    begin_addr = 6'd10; end_addr = 6'd13; start = 1;
    base = log_a.size();
    wait_done_a(20);
    chk("post_reset_count", log_a.size() - base, 1);
    if (log_a.size() > base) begin
      chk("post_reset_addr", log_a[base].addr, 10);
      chk("post_reset_len", log_a[base].len, 3);
    end
    start = 0;
    @(negedge clk);

    // deep-credit instance: back-to-back bursts
    begin_addr = 6'd0; end_addr = 6'd16; start_b = 1;
    n = 0; early = 0;
    while (!done_b && n < 60) begin
      @(negedge clk); n++;
      if (done_b && cpl_cnt_b < 4) early = 1;
    end
    chk("b_done", done_b, 1);
    chk("b_done_after_cpl4", early, 0);
    chk("b_cpl_count", cpl_cnt_b, 4);
    chk("b_count", log_b.size(), 4);
    for (int i = 0; i < log_b.size() && i < 4; i++) begin
      chk("b_addr", log_b[i].addr, 4 * i);
      chk("b_len", log_b[i].len, 4);
    end
    chk("b_aborted", aborted_b, 0);
    start_b = 0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
